// File: rtl/p_beid_interconnect_f0_ahb_mtx_pkg.sv
// Shared AHB encodings and input-stage state encoding for the matrix.
package p_beid_interconnect_f0_ahb_mtx_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  // IDLE: nothing pending; HOLD: transfer registered awaiting grant;
  // DATA: granted transfer in data phase; HOLD_DATA: data phase plus held
  // next transfer (unreachable with wait-derived HREADYS).
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_HOLD      = 2'b01,
    ST_DATA      = 2'b10,
    ST_HOLD_DATA = 2'b11
  } in_state_e;

endpackage

// File: rtl/p_beid_interconnect_f0_ahb_mtx_in_hold.sv
// Address-phase hold register bank with load enable and synchronous clear.
module p_beid_interconnect_f0_ahb_mtx_in_hold
  import p_beid_interconnect_f0_ahb_mtx_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [1:0]            i_htrans,
  input  logic                  i_hwrite,
  input  logic [2:0]            i_hsize,
  input  logic [2:0]            i_hburst,
  input  logic [3:0]            i_hprot,
  input  logic                  i_hmastlock,
  output logic [ADDR_WIDTH-1:0] o_haddr,
  output logic [1:0]            o_htrans,
  output logic                  o_hwrite,
  output logic [2:0]            o_hsize,
  output logic [2:0]            o_hburst,
  output logic [3:0]            o_hprot,
  output logic                  o_hmastlock
);

  logic [ADDR_WIDTH-1:0] r_haddr;
  logic [1:0]            r_htrans;
  logic                  r_hwrite;
  logic [2:0]            r_hsize;
  logic [2:0]            r_hburst;
  logic [3:0]            r_hprot;
  logic                  r_hmastlock;

  // Clear wins over load; otherwise capture the master's address phase on load.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_haddr     <= '0;
      r_htrans    <= HTRANS_IDLE;
      r_hwrite    <= 1'b0;
      r_hsize     <= '0;
      r_hburst    <= '0;
      r_hprot     <= '0;
      r_hmastlock <= 1'b0;
    end else if (i_load) begin
      r_haddr     <= i_haddr;
      r_htrans    <= i_htrans;
      r_hwrite    <= i_hwrite;
      r_hsize     <= i_hsize;
      r_hburst    <= i_hburst;
      r_hprot     <= i_hprot;
      r_hmastlock <= i_hmastlock;
    end
  end

  assign o_haddr     = r_haddr;
  assign o_htrans    = r_htrans;
  assign o_hwrite    = r_hwrite;
  assign o_hsize     = r_hsize;
  assign o_hburst    = r_hburst;
  assign o_hprot     = r_hprot;
  assign o_hmastlock = r_hmastlock;

endmodule

// File: rtl/p_beid_interconnect_f0_ahb_mtx_in_stage.sv
// AHB matrix input stage: holds a master transfer until the output-stage
// arbiter grants it, and routes data-phase ready/response back to the master.
module p_beid_interconnect_f0_ahb_mtx_in_stage
  import p_beid_interconnect_f0_ahb_mtx_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  input  logic                  active_trans,
  input  logic                  HREADYM,
  input  logic [1:0]            HRESPM,
  output logic                  trans_pend,
  output logic [ADDR_WIDTH-1:0] HADDRM,
  output logic [1:0]            HTRANSM,
  output logic                  HWRITEM,
  output logic [2:0]            HSIZEM,
  output logic [2:0]            HBURSTM,
  output logic [3:0]            HPROTM,
  output logic                  HMASTLOCKM,
  output logic                  HREADYOUTS,
  output logic [1:0]            HRESPS
);

  in_state_e r_state;
  in_state_e w_next;
  logic      w_new_tran;
  logic      w_load;
  logic      w_held;

  logic [ADDR_WIDTH-1:0] w_hold_haddr;
  logic [1:0]            w_hold_htrans;
  logic                  w_hold_hwrite;
  logic [2:0]            w_hold_hsize;
  logic [2:0]            w_hold_hburst;
  logic [3:0]            w_hold_hprot;
  logic                  w_hold_hmastlock;

  assign w_new_tran = HSELS & HTRANSS[1] & HREADYS;
  assign w_held     = (r_state == ST_HOLD);

  p_beid_interconnect_f0_ahb_mtx_in_hold #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_hold (
    .i_clk       (HCLK),
    .i_clr       (~HRESETn),
    .i_load      (w_load),
    .i_haddr     (HADDRS),
    .i_htrans    (HTRANSS),
    .i_hwrite    (HWRITES),
    .i_hsize     (HSIZES),
    .i_hburst    (HBURSTS),
    .i_hprot     (HPROTS),
    .i_hmastlock (HMASTLOCKS),
    .o_haddr     (w_hold_haddr),
    .o_htrans    (w_hold_htrans),
    .o_hwrite    (w_hold_hwrite),
    .o_hsize     (w_hold_hsize),
    .o_hburst    (w_hold_hburst),
    .o_hprot     (w_hold_hprot),
    .o_hmastlock (w_hold_hmastlock)
  );

  // State register; reset discards any held transfer.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state and hold-bank load; a grant in the capture cycle bypasses the hold.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_new_tran) begin
          if (active_trans && HREADYM) begin
            w_next = ST_DATA;
          end else begin
            w_load = 1'b1;
            w_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (active_trans && HREADYM) w_next = ST_DATA;
      end
      ST_DATA: begin
        // A new transfer during a data-phase wait is a protocol error and is dropped.
        if (HREADYM) begin
          if (!w_new_tran) begin
            w_next = ST_IDLE;
          end else if (active_trans) begin
            w_next = ST_DATA;
          end else begin
            w_load = 1'b1;
            w_next = ST_HOLD;
          end
        end
      end
      ST_HOLD_DATA: begin
        w_next = ST_DATA;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Address-phase mux (held vs live) and master-side ready/response.
  always_comb begin
    HADDRM     = HADDRS;
    HTRANSM    = w_new_tran ? HTRANSS : HTRANS_IDLE;
    HWRITEM    = HWRITES;
    HSIZEM     = HSIZES;
    HBURSTM    = HBURSTS;
    HPROTM     = HPROTS;
    HMASTLOCKM = HMASTLOCKS;
    trans_pend = w_new_tran;
    HREADYOUTS = 1'b1;
    HRESPS     = HRESP_OKAY;
    if (w_held) begin
      HADDRM     = w_hold_haddr;
      HTRANSM    = w_hold_htrans;
      HWRITEM    = w_hold_hwrite;
      HSIZEM     = w_hold_hsize;
      HBURSTM    = w_hold_hburst;
      HPROTM     = w_hold_hprot;
      HMASTLOCKM = w_hold_hmastlock;
      trans_pend = 1'b1;
      HREADYOUTS = 1'b0;
    end else if (r_state == ST_DATA || r_state == ST_HOLD_DATA) begin
      HREADYOUTS = HREADYM;
      HRESPS     = HRESPM;
    end
  end

endmodule
